// File: rtl/serial_seq_feeder.sv
// serial_seq_feeder: serialises WIDTH-bit words MSB-first onto the 10011 detector input x.
// Define SERIAL_FEEDER_PRELOAD_EN to add a one-word hold register for gapless streaming.
module serial_seq_feeder #(
    parameter int   WIDTH    = 10,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             accept;

`ifdef SERIAL_FEEDER_PRELOAD_EN
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
`endif

    // valid/ready: a word transfers on a posedge where din_valid && din_ready are both 1;
    // din_ready is registered, and din_valid seen while din_ready=0 is simply dropped.
    assign accept    = din_valid & din_ready;
    assign state_dbg = (state == SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_FEEDER_PRELOAD_EN
            hold_full <= 1'b0;
            hold_data <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    x         <= IDLE_BIT;
                    x_valid   <= 1'b0;
                    busy      <= 1'b0;
                    din_ready <= 1'b1;
                    if (accept) begin
                        state   <= SHIFT;
                        shreg   <= din;
                        x       <= din[WIDTH-1];
                        x_valid <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= CNT_INIT;
`ifdef SERIAL_FEEDER_PRELOAD_EN
                        din_ready <= 1'b1;
`else
                        din_ready <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        shreg   <= shreg << 1;
                        x       <= shreg[WIDTH-2];
                        bit_cnt <= bit_cnt - 1'b1;
`ifdef SERIAL_FEEDER_PRELOAD_EN
                        if (accept) begin
                            hold_data <= din;
                            hold_full <= 1'b1;
                            din_ready <= 1'b0;
                        end
`endif
                    end else begin
`ifdef SERIAL_FEEDER_PRELOAD_EN
                        // Last bit is on x: chain straight into the next word if one is ready.
                        if (hold_full) begin
                            shreg     <= hold_data;
                            x         <= hold_data[WIDTH-1];
                            bit_cnt   <= CNT_INIT;
                            hold_full <= accept;
                            din_ready <= !accept;
                            if (accept) begin
                                hold_data <= din;
                            end
                        end else if (accept) begin
                            shreg   <= din;
                            x       <= din[WIDTH-1];
                            bit_cnt <= CNT_INIT;
                        end else begin
                            state     <= IDLE;
                            x         <= IDLE_BIT;
                            x_valid   <= 1'b0;
                            busy      <= 1'b0;
                            din_ready <= 1'b1;
                        end
`else
                        state     <= IDLE;
                        x         <= IDLE_BIT;
                        x_valid   <= 1'b0;
                        busy      <= 1'b0;
                        din_ready <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
